pe_postproc: RTL and testbench
==============================

// Module: pe_postproc
// PURPOSE
//  Sits directly downstream of pe_engine. Accumulates Tout-wide partial sums across input-channel tiles in a per-pixel psum RAM.
//  On the last channel tile it adds bias, requantizes (round, shift, saturate) and applies optional leaky-ReLU.
//  Writes Tout int8 results per pixel to the output buffer. No backpressure: one pixel accepted per cycle, always.
// PARAMETERS
//  Tout      4   output channels per pixel (lanes)
//  W_PSUM    32  signed psum/bias width per lane
//  W_SIZE    9   row/col width
//  W_CHANNEL 9   channel-tile index width
//  OUT_DW    8   signed output width per lane
//  PSUM_AW   12  psum RAM address width (max q_width*q_height = 2**PSUM_AW)
// PORTS
//  clk            in   1               clock
//  rst            in   1               synchronous, active-high reset
//  q_width        in   W_SIZE          layer map width (static during tile)
//  q_height       in   W_SIZE          layer map height (static during tile)
//  q_shift        in   5               requant right-shift amount, 0..31
//  q_act_en       in   1               1 = leaky-ReLU enabled
//  i_bias_wr      in   1               bias register write strobe
//  i_bias_idx     in   2               lane index for bias write
//  i_bias_data    in   W_PSUM          signed bias value
//  i_pe_data      in   Tout*W_PSUM     lane k at [k*W_PSUM +: W_PSUM]
//  i_pe_vld       in   1               pixel valid
//  i_pe_row       in   W_SIZE          pixel row
//  i_pe_col       in   W_SIZE          pixel col
//  i_pe_chn       in   W_CHANNEL       input-channel tile; 0 = first
//  i_pe_chn_out   in   W_CHANNEL       output-channel tile
//  i_pe_is_last_chn in 1               last input-channel tile
//  o_ob_wr        out  1               output buffer write strobe
//  o_ob_addr      out  PSUM_AW         row*q_width+col
//  o_ob_chn_out   out  W_CHANNEL       passthrough chn_out
//  o_ob_data      out  Tout*OUT_DW     lane k at [k*OUT_DW +: OUT_DW]
//  o_tile_done    out  1               1-cycle pulse with last pixel write of a chn_out tile
// BEHAVIOUR
//  Reset: o_ob_wr, o_ob_addr, o_ob_chn_out, o_ob_data, o_tile_done = 0.
//    Also clears all pipeline valids, the bypass register and the bias registers. psum RAM contents are not cleared.
//  Pipeline, fully pipelined, 1 pixel/cycle:
//    C0: addr = row*q_width+col; RAM sync read issued.
//    S1: acc = (chn==0) ? pe : src+pe, wrapping W_PSUM two's complement.
//        If !last_chn, write acc back to RAM[addr].
//    S2: b = acc + bias[k], W_PSUM+1 bits.
//    S3: output register.
//  Latency: i_pe_vld at cycle t -> o_ob_wr at t+3, only when is_last_chn. Non-last tiles produce no output.
//  Hazard: RAM is read-before-write. Keep a 1-entry bypass {valid, addr, data} of the previous cycle's S1 write.
//    src = bypass data if bypass.valid && bypass.addr==S1 addr, else RAM read data.
//    Distance-1 is the only hazard; 1x1 maps with back-to-back tiles must be correct.
//  Requant per lane, on b:
//    r = (q_shift==0) ? b : (b + (1<<(q_shift-1))) >>> q_shift   (round half up)
//    if q_act_en && r<0 then r = r >>> 3   (floor)
//    saturate r to [-128,127]
//  Bias: i_bias_wr writes bias[i_bias_idx], visible from the next cycle.
//    The controller loads bias before the first last-chn pixel of each chn_out tile.
//    A write in the same cycle as an S2 read returns the old value.
//  o_tile_done: asserted with o_ob_wr when row==q_height-1 && col==q_width-1 && last_chn.
//  rst mid-stream: in-flight pixels are dropped and no o_ob_wr follows. The next tile must restart at chn 0.
//  i_pe_vld=0: bubbles propagate; no RAM write, no output.
// STRUCTURE
//  Shared package/header: Tout, W_PSUM, OUT_DW, PSUM_AW, lane slice macros, requant constants (leaky shift = 3).
//  Sub-module psum_ram: 1R1W sync-read RAM, Tout*W_PSUM wide, 2**PSUM_AW deep, read-before-write.
//  Top holds the pipeline, bypass, bias regs and requant lanes (generate loop over Tout).
// TESTING
//  1. chn=0, last, pe={10,-5,300,-300}, bias 0, shift 0, act off
//     -> o_ob_data lanes {10,-5,127,-128} at t+3; addr = row*q_width+col.
//  2. 1x1 map, back-to-back chn0 pe={1,2,3,4} then chn1 (last) pe={10,20,30,40}
//     -> {11,22,33,44}, exercising the bypass.
//  3. shift=2, bias 0, psums {6,-6,5,-2}
//     -> {2,-1,1,0}.
//  4. act_en=1, shift 0, psums {-64,64,-1,-2000}
//     -> {-8,64,-1,-128}.
//     Bias {100,0,0,0} on psum {-100,...} -> lane0 0.
//  5. q_width=4, q_height=2, 2 chn tiles, 16 consecutive pixels
//     -> 8 writes only on tile 2; o_tile_done only with (1,3).
//  6. rst asserted 1 cycle after a last-chn vld -> no o_ob_wr, all outputs 0 next cycle.

Source files
------------

// File: rtl/pe_postproc_pkg.sv
// Shared constants and the per-lane requantizer for the pe_engine post-processor.
package pe_postproc_pkg;

  localparam int TOUT        = 4;   // output-channel lanes per pixel
  localparam int W_PSUM      = 32;  // signed psum / bias width per lane
  localparam int W_SIZE      = 9;   // row / col width
  localparam int W_CHANNEL   = 9;   // channel-tile index width
  localparam int OUT_DW      = 8;   // signed output width per lane
  localparam int PSUM_AW     = 12;  // psum RAM address width
  localparam int W_SHIFT     = 5;   // requant shift field width
  localparam int LEAKY_SHIFT = 3;   // leaky-ReLU slope is 1/8

  localparam int W_B  = W_PSUM + 1;  // psum + bias, no overflow
  localparam int W_RQ = W_PSUM + 2;  // headroom for the rounding add

  localparam logic signed [W_RQ-1:0] RQ_MAX = W_RQ'(127);
  localparam logic signed [W_RQ-1:0] RQ_MIN = -W_RQ'(128);

  // Round-half-up right shift, optional leaky-ReLU (floor), saturate to int8.
  function automatic logic signed [OUT_DW-1:0] requant(
    input logic signed [W_B-1:0]     b,
    input logic        [W_SHIFT-1:0] shift,
    input logic                      act_en
  );
    logic signed [W_RQ-1:0] r;
    logic signed [W_RQ-1:0] half;
    r    = {{(W_RQ - W_B){b[W_B-1]}}, b};
    half = '0;
    if (shift != '0) begin
      half = {{(W_RQ - 1){1'b0}}, 1'b1} << (shift - 5'd1);
      r    = (r + half) >>> shift;
    end
    if (act_en && (r < 0)) begin
      r = r >>> LEAKY_SHIFT;
    end
    if (r > RQ_MAX) begin
      requant = RQ_MAX[OUT_DW-1:0];
    end else if (r < RQ_MIN) begin
      requant = RQ_MIN[OUT_DW-1:0];
    end else begin
      requant = r[OUT_DW-1:0];
    end
  endfunction

endpackage

// File: rtl/pe_postproc_psum_ram.sv
// Per-pixel partial-sum store: 1R1W, synchronous read, read-before-write.
module pe_postproc_psum_ram
  import pe_postproc_pkg::*;
(
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [PSUM_AW-1:0]       i_waddr,
  input  logic [TOUT*W_PSUM-1:0]   i_wdata,
  input  logic [PSUM_AW-1:0]       i_raddr,
  output logic [TOUT*W_PSUM-1:0]   o_rdata
);

  logic [TOUT*W_PSUM-1:0] r_mem [2**PSUM_AW];

  // Registered read returns the old word when the same address is written this cycle.
  always_ff @(posedge clk) begin
    o_rdata <= r_mem[i_raddr];
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

endmodule

// File: rtl/pe_postproc.sv
// Post-processor behind pe_engine: psum accumulation over input-channel tiles,
// then bias, requantization and optional leaky-ReLU on the last tile.
module pe_postproc
  import pe_postproc_pkg::*;
(
  input  logic                         clk,
  input  logic                         rst,
  input  logic [W_SIZE-1:0]            q_width,
  input  logic [W_SIZE-1:0]            q_height,
  input  logic [W_SHIFT-1:0]           q_shift,
  input  logic                         q_act_en,
  input  logic                         i_bias_wr,
  input  logic [1:0]                   i_bias_idx,
  input  logic [W_PSUM-1:0]            i_bias_data,
  input  logic [TOUT*W_PSUM-1:0]       i_pe_data,
  input  logic                         i_pe_vld,
  input  logic [W_SIZE-1:0]            i_pe_row,
  input  logic [W_SIZE-1:0]            i_pe_col,
  input  logic [W_CHANNEL-1:0]         i_pe_chn,
  input  logic [W_CHANNEL-1:0]         i_pe_chn_out,
  input  logic                         i_pe_is_last_chn,
  output logic                         o_ob_wr,
  output logic [PSUM_AW-1:0]           o_ob_addr,
  output logic [W_CHANNEL-1:0]         o_ob_chn_out,
  output logic [TOUT*OUT_DW-1:0]       o_ob_data,
  output logic                         o_tile_done
);

  // ---------------- C0: address and RAM read ----------------
  logic [PSUM_AW-1:0]      w_c0_addr;
  logic                    w_c0_end;
  logic [TOUT*W_PSUM-1:0]  w_ram_rdata;

  assign w_c0_addr = PSUM_AW'(i_pe_row) * PSUM_AW'(q_width) + PSUM_AW'(i_pe_col);
  assign w_c0_end  = (i_pe_row == q_height - 1'b1) && (i_pe_col == q_width - 1'b1);

  // ---------------- S1 state ----------------
  logic                    r_s1_vld;
  logic [PSUM_AW-1:0]      r_s1_addr;
  logic [TOUT*W_PSUM-1:0]  r_s1_pe;
  logic                    r_s1_first;
  logic                    r_s1_last;
  logic                    r_s1_end;
  logic [W_CHANNEL-1:0]    r_s1_chn_out;

  logic                    r_byp_vld;
  logic [PSUM_AW-1:0]      r_byp_addr;
  logic [TOUT*W_PSUM-1:0]  r_byp_data;

  logic [TOUT*W_PSUM-1:0]  w_s1_src;
  logic [TOUT*W_PSUM-1:0]  w_s1_acc;
  logic                    w_s1_we;

  pe_postproc_psum_ram u_psum_ram (
    .clk     (clk),
    .i_we    (w_s1_we),
    .i_waddr (r_s1_addr),
    .i_wdata (w_s1_acc),
    .i_raddr (w_c0_addr),
    .o_rdata (w_ram_rdata)
  );

  // Capture C0 pixel into S1; only the valid flag needs a reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1_vld <= 1'b0;
    end else begin
      r_s1_vld <= i_pe_vld;
    end
    r_s1_addr    <= w_c0_addr;
    r_s1_pe      <= i_pe_data;
    r_s1_first   <= (i_pe_chn == '0);
    r_s1_last    <= i_pe_is_last_chn;
    r_s1_end     <= w_c0_end;
    r_s1_chn_out <= i_pe_chn_out;
  end

  // The RAM read for this S1 pixel was issued before the previous pixel's
  // write landed, so a same-address write one cycle back must be forwarded.
  assign w_s1_src = (r_byp_vld && (r_byp_addr == r_s1_addr)) ? r_byp_data : w_ram_rdata;
  assign w_s1_we  = r_s1_vld && !r_s1_last;

  generate
    for (genvar gi = 0; gi < TOUT; gi++) begin : g_acc
      assign w_s1_acc[gi*W_PSUM +: W_PSUM] = r_s1_first
        ? r_s1_pe[gi*W_PSUM +: W_PSUM]
        : w_s1_src[gi*W_PSUM +: W_PSUM] + r_s1_pe[gi*W_PSUM +: W_PSUM];
    end
  endgenerate

  // Remember the last S1 write so the following pixel can bypass the RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_byp_vld  <= 1'b0;
      r_byp_addr <= '0;
      r_byp_data <= '0;
    end else begin
      r_byp_vld  <= w_s1_we;
      r_byp_addr <= r_s1_addr;
      r_byp_data <= w_s1_acc;
    end
  end

  // ---------------- S2: bias and requant ----------------
  logic                    r_s2_vld;
  logic [TOUT*W_PSUM-1:0]  r_s2_acc;
  logic [PSUM_AW-1:0]      r_s2_addr;
  logic                    r_s2_end;
  logic [W_CHANNEL-1:0]    r_s2_chn_out;
  logic [W_PSUM-1:0]       r_bias [TOUT];
  logic [TOUT*OUT_DW-1:0]  w_s2_q;

  // Only last-tile pixels travel beyond S1; earlier tiles just update the RAM.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s2_vld <= 1'b0;
    end else begin
      r_s2_vld <= r_s1_vld && r_s1_last;
    end
    r_s2_acc     <= w_s1_acc;
    r_s2_addr    <= r_s1_addr;
    r_s2_end     <= r_s1_end;
    r_s2_chn_out <= r_s1_chn_out;
  end

  // Bias registers; a write takes effect on the following cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < TOUT; k++) begin
        r_bias[k] <= '0;
      end
    end else if (i_bias_wr) begin
      r_bias[i_bias_idx] <= i_bias_data;
    end
  end

  generate
    for (genvar gi = 0; gi < TOUT; gi++) begin : g_lane
      logic signed [W_B-1:0] w_b;
      assign w_b = $signed({r_s2_acc[gi*W_PSUM + W_PSUM - 1], r_s2_acc[gi*W_PSUM +: W_PSUM]})
                 + $signed({r_bias[gi][W_PSUM-1], r_bias[gi]});
      assign w_s2_q[gi*OUT_DW +: OUT_DW] = requant(w_b, q_shift, q_act_en);
    end
  endgenerate

  // ---------------- S3: output register ----------------
  always_ff @(posedge clk) begin
    if (rst) begin
      o_ob_wr      <= 1'b0;
      o_ob_addr    <= '0;
      o_ob_chn_out <= '0;
      o_ob_data    <= '0;
      o_tile_done  <= 1'b0;
    end else begin
      o_ob_wr     <= r_s2_vld;
      o_tile_done <= r_s2_vld && r_s2_end;
      if (r_s2_vld) begin
        o_ob_addr    <= r_s2_addr;
        o_ob_chn_out <= r_s2_chn_out;
        o_ob_data    <= w_s2_q;
      end
    end
  end

endmodule

// File: tb/tb_pe_postproc.sv
// Directed self-checking bench for pe_postproc.
module tb_pe_postproc;
  import pe_postproc_pkg::*;

  logic                     clk;
  logic                     rst;
  logic [W_SIZE-1:0]        q_width;
  logic [W_SIZE-1:0]        q_height;
  logic [W_SHIFT-1:0]       q_shift;
  logic                     q_act_en;
  logic                     i_bias_wr;
  logic [1:0]               i_bias_idx;
  logic [W_PSUM-1:0]        i_bias_data;
  logic [TOUT*W_PSUM-1:0]   i_pe_data;
  logic                     i_pe_vld;
  logic [W_SIZE-1:0]        i_pe_row;
  logic [W_SIZE-1:0]        i_pe_col;
  logic [W_CHANNEL-1:0]     i_pe_chn;
  logic [W_CHANNEL-1:0]     i_pe_chn_out;
  logic                     i_pe_is_last_chn;
  logic                     o_ob_wr;
  logic [PSUM_AW-1:0]       o_ob_addr;
  logic [W_CHANNEL-1:0]     o_ob_chn_out;
  logic [TOUT*OUT_DW-1:0]   o_ob_data;
  logic                     o_tile_done;

  int n_pass  = 0;
  int n_total = 0;

  logic [PSUM_AW-1:0]     q_addr [$];
  logic [TOUT*OUT_DW-1:0] q_data [$];
  logic                   q_done [$];

  pe_postproc dut (
    .clk              (clk),
    .rst              (rst),
    .q_width          (q_width),
    .q_height         (q_height),
    .q_shift          (q_shift),
    .q_act_en         (q_act_en),
    .i_bias_wr        (i_bias_wr),
    .i_bias_idx       (i_bias_idx),
    .i_bias_data      (i_bias_data),
    .i_pe_data        (i_pe_data),
    .i_pe_vld         (i_pe_vld),
    .i_pe_row         (i_pe_row),
    .i_pe_col         (i_pe_col),
    .i_pe_chn         (i_pe_chn),
    .i_pe_chn_out     (i_pe_chn_out),
    .i_pe_is_last_chn (i_pe_is_last_chn),
    .o_ob_wr          (o_ob_wr),
    .o_ob_addr        (o_ob_addr),
    .o_ob_chn_out     (o_ob_chn_out),
    .o_ob_data        (o_ob_data),
    .o_tile_done      (o_tile_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Log every output-buffer write, sampled mid-cycle.
  always @(negedge clk) begin
    if (o_ob_wr === 1'b1) begin
      q_addr.push_back(o_ob_addr);
      q_data.push_back(o_ob_data);
      q_done.push_back(o_tile_done);
      $display("wr addr=%0d chn_out=%0d data=%h done=%0b", o_ob_addr, o_ob_chn_out, o_ob_data, o_tile_done);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [31:0] pack8(input int a, input int b, input int c, input int d);
    pack8 = {d[7:0], c[7:0], b[7:0], a[7:0]};
  endfunction

  task automatic drive(input int row, input int col, input int chn, input int chn_out,
                       input logic last, input int l0, input int l1, input int l2, input int l3);
    i_pe_vld         = 1'b1;
    i_pe_row         = W_SIZE'(row);
    i_pe_col         = W_SIZE'(col);
    i_pe_chn         = W_CHANNEL'(chn);
    i_pe_chn_out     = W_CHANNEL'(chn_out);
    i_pe_is_last_chn = last;
    i_pe_data        = {l3, l2, l1, l0};
  endtask

  task automatic idle;
    i_pe_vld         = 1'b0;
    i_pe_is_last_chn = 1'b0;
  endtask

  // Single last-tile pixel; checks the write 3 cycles later.
  task automatic one_pixel(input string tag, input int row, input int col,
                           input int l0, input int l1, input int l2, input int l3,
                           input logic [31:0] exp_data, input int exp_addr);
    drive(row, col, 0, 2, 1'b1, l0, l1, l2, l3);
    tick;
    idle;
    tick;
    tick;
    chk({tag, "_wr"}, 32'(o_ob_wr), 32'd1);
    chk({tag, "_data"}, o_ob_data, exp_data);
    chk({tag, "_addr"}, 32'(o_ob_addr), 32'(exp_addr));
    tick;
  endtask

  initial begin
    rst = 1'b1;
    q_width = 9'd8; q_height = 9'd8; q_shift = '0; q_act_en = 1'b0;
    i_bias_wr = 1'b0; i_bias_idx = '0; i_bias_data = '0;
    i_pe_data = '0; i_pe_vld = 1'b0; i_pe_row = '0; i_pe_col = '0;
    i_pe_chn = '0; i_pe_chn_out = '0; i_pe_is_last_chn = 1'b0;
    tick;
    tick;
    chk("rst_wr", 32'(o_ob_wr), 32'd0);
    chk("rst_addr", 32'(o_ob_addr), 32'd0);
    chk("rst_data", o_ob_data, 32'd0);
    chk("rst_done", 32'(o_tile_done), 32'd0);
    chk("rst_chn_out", 32'(o_ob_chn_out), 32'd0);
    rst = 1'b0;
    tick;

    // Saturation and latency: nothing before t+3, then addr 2*8+3.
    drive(2, 3, 0, 5, 1'b1, 10, -5, 300, -300);
    tick;
    idle;
    tick;
    chk("t1_nowr_early", 32'(o_ob_wr), 32'd0);
    tick;
    chk("t1_wr", 32'(o_ob_wr), 32'd1);
    chk("t1_data", o_ob_data, pack8(10, -5, 127, -128));
    chk("t1_addr", 32'(o_ob_addr), 32'd19);
    chk("t1_chn_out", 32'(o_ob_chn_out), 32'd5);
    chk("t1_done", 32'(o_tile_done), 32'd0);
    tick;
    chk("t1_wr_pulse", 32'(o_ob_wr), 32'd0);

    // 1x1 map, back-to-back tiles: relies on the bypass.
    q_width = 9'd1; q_height = 9'd1;
    drive(0, 0, 0, 1, 1'b0, 1, 2, 3, 4);
    tick;
    drive(0, 0, 1, 1, 1'b1, 10, 20, 30, 40);
    tick;
    idle;
    tick;
    tick;
    chk("t2_wr", 32'(o_ob_wr), 32'd1);
    chk("t2_data", o_ob_data, pack8(11, 22, 33, 44));
    chk("t2_done", 32'(o_tile_done), 32'd1);
    tick;

    // Rounding shifts.
    q_width = 9'd8; q_height = 9'd8;
    q_shift = 5'd2;
    one_pixel("t3", 1, 1, 6, -6, 5, -2, pack8(2, -1, 1, 0), 9);
    q_shift = 5'd1;
    one_pixel("t3b", 0, 7, -3, 3, 1, -1, pack8(-1, 2, 1, 0), 7);

    // Leaky-ReLU.
    q_shift = 5'd0;
    q_act_en = 1'b1;
    one_pixel("t4", 7, 7, -64, 64, -1, -2000, pack8(-8, 64, -1, -128), 63);
    q_act_en = 1'b0;

    // Bias.
    i_bias_wr = 1'b1; i_bias_idx = 2'd0; i_bias_data = 32'd100;
    tick;
    i_bias_wr = 1'b0;
    one_pixel("t4_bias", 0, 0, -100, 5, 0, 0, pack8(0, 5, 0, 0), 0);
    i_bias_wr = 1'b1; i_bias_data = 32'd0;
    tick;
    i_bias_wr = 1'b0;
    tick;

    // 4x2 map, two input-channel tiles streamed back to back.
    q_width = 9'd4; q_height = 9'd2;
    q_addr.delete(); q_data.delete(); q_done.delete();
    for (int p = 0; p < 8; p++) begin
      drive(p / 4, p % 4, 0, 3, 1'b0, p, -p, 2 * p, 0);
      tick;
    end
    for (int p = 0; p < 8; p++) begin
      drive(p / 4, p % 4, 1, 3, 1'b1, 1, 1, 1, 1);
      tick;
    end
    idle;
    tick; tick; tick; tick;
    chk("t5_count", 32'(q_addr.size()), 32'd8);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("t5_addr%0d", i), 32'(q_addr[i]), 32'(i));
      chk($sformatf("t5_data%0d", i), q_data[i], pack8(i + 1, 1 - i, 2 * i + 1, 1));
      chk($sformatf("t5_done%0d", i), 32'(q_done[i]), (i == 7) ? 32'd1 : 32'd0);
    end

    // Reset one cycle after a last-tile pixel drops it.
    drive(1, 2, 0, 4, 1'b1, 50, 50, 50, 50);
    tick;
    idle;
    rst = 1'b1;
    tick;
    chk("t6_wr", 32'(o_ob_wr), 32'd0);
    chk("t6_addr", 32'(o_ob_addr), 32'd0);
    chk("t6_data", o_ob_data, 32'd0);
    chk("t6_done", 32'(o_tile_done), 32'd0);
    rst = 1'b0;
    tick; tick; tick;
    chk("t6_no_late_wr", 32'(q_addr.size()), 32'd8);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
